up_ramcfg_nr1w_lat: RTL
=======================

// Module: up_ramcfg_nr1w_lat
// PURPOSE
//  Generalised config-RAM macro: G_NENG engine read ports plus one CPU (up protocol) rd/wr port onto
//  G_NENG-port external memory (rtlmem_*rw* style). Engine 0 shares memory port 0 with CPU; engines 1..N-1
//  own ports 1..N-1 read-only. Adds configurable read latency, per-engine read-valid, CPU starvation
//  guard, write-to-read bypass. Sits between CPU register decoder and engine lookup datapaths.
// PARAMETERS
//  G_ADDR    10  address width
//  G_WIDTH   32  data width
//  G_NENG    2   engine read ports (>=1); memory ports = G_NENG
//  G_LAT     3   memory read latency in clk (>=1); eng/cpu read data valid G_LAT cycles after issue
//  G_STARVE  15  max consecutive cycles CPU may be blocked by engine 0 before forced grant (>=1)
//  G_BYPASS  1   1: forward same-cycle CPU write data to colliding engine reads; 0: memory handles it
// PORTS
//  clk       in  1               clock, all logic rising edge
//  rst       in  1               synchronous reset, active-high
//  eng_re    in  G_NENG          engine read enable, bit i = engine i
//  eng_ra    in  G_NENG*G_ADDR   engine read address, slice i = engine i
//  eng_rdd   out G_NENG*G_WIDTH  engine read data, valid when eng_rvld[i]
//  eng_rvld  out G_NENG          read data valid, G_LAT cycles after accepted eng_re
//  upen      in  1               CPU access window; low = timeout/abort
//  upa       in  G_ADDR          CPU address
//  upws      in  1               CPU write strobe
//  uprs      in  1               CPU read strobe
//  updi      in  G_WIDTH         CPU write data
//  updo      out G_WIDTH         CPU read data, valid when uprdy
//  uprdy     out 1               one-cycle access-done pulse
//  omemwe    out G_NENG          memory write enable per port (only bit 0 may assert)
//  omemad    out G_NENG*G_ADDR   memory address per port
//  omemdi    out G_NENG*G_WIDTH  memory write data per port
//  imemdo    in  G_NENG*G_WIDTH  memory read data per port (G_LAT after address)
// BEHAVIOUR
//  Reset: all pipelines, latches, counters cleared; eng_rvld=0, uprdy=0, omemwe=0, updo/eng_rdd=0 until
//   first valid; CPU FSM -> IDLE. Reset mid-access drops it, no uprdy.
//  CPU FSM: IDLE -> (upen&(upws|uprs)) PEND; PEND -> grant -> BUSY; BUSY counts G_LAT cycles -> DONE;
//   DONE: uprdy=1 one cycle -> WAITREL; WAITREL -> IDLE when upen=0 or both strobes low (no re-trigger on
//   held strobes). Grant may fire in IDLE same cycle as request (zero wait). upws&uprs together = write.
//  Grant (port 0): !eng_re[0] | (eng_ra[0]==upa) | starve_cnt==G_STARVE. starve_cnt counts blocked PEND
//   cycles, saturates at G_STARVE, clears on grant/IDLE.
//  Forced grant: CPU owns port 0; engine 0 read that cycle dropped -> eng_rvld[0]=0 G_LAT later.
//  Port 0 addr: CPU addr on grant cycle, else eng_ra[0]. omemwe[0]=grant&write; omemdi[0]=updi.
//  Ports i>=1: omemad[i]=eng_ra[i], omemwe[i]=0, omemdi[i]=0.
//  eng_rvld[i] = eng_re[i] (accepted) delayed G_LAT; eng_rdd[i]=imemdo[i] or bypass data.
//  Bypass (G_BYPASS=1): write grant & eng_re[i] & eng_ra[i]==upa -> updi value registered and
//   delivered on eng_rdd[i] at that read's G_LAT slot (data captured at issue, not at output).
//  Same-addr read grant (eng_ra[0]==upa): engine 0 and CPU both served from one memory access.
//  updo: imemdo[0] sampled in DONE for reads, held until next read completes; writes leave updo unchanged.
//  upen low in PEND/BUSY: abort -> IDLE, uprdy suppressed; issued write still completes in memory.
//  Latency: eng_re -> eng_rvld = G_LAT; CPU grant -> uprdy = G_LAT+1 cycles.
// TESTING
//  1 G_LAT=3: eng_re[1]=1, eng_ra[1]=0x010, imemdo[1]=0xA5A5_0001 at +3 -> eng_rvld[1]=1, eng_rdd=0xA5A5_0001 @+3.
//  2 CPU write 0x020 data 0xDEAD_BEEF, eng_re[0]=0 -> omemwe[0]=1 same cycle, uprdy pulse @+4, one cycle only.
//  3 eng_re[0] held on 0x001, CPU read 0x002 -> blocked 15 cycles, forced grant cycle 16, eng_rvld[0]=0 @+3.
//  4 Write 0x030=0x1234_5678 same cycle as eng_re[1] on 0x030 (G_BYPASS=1) -> eng_rdd[1]=0x1234_5678 @+3.
//  5 CPU read pending blocked, upen dropped cycle 2 -> no uprdy, FSM IDLE, next access completes normally.
//  6 rst=1 during BUSY -> uprdy, eng_rvld, omemwe all 0 next cycle; no stale uprdy after rst release.

Source files
------------

// File: rtl/up_ramcfg_nr1w_lat.sv
// Config-RAM front end: G_NENG engine read ports plus one CPU rd/wr port sharing memory port 0.
// Adds read-latency pipelines, CPU starvation guard and write-to-read bypass.
//
// state   | meaning
// IDLE    | no CPU access; a new request may be granted in this same cycle
// PEND    | CPU request waiting for port 0 (engine 0 holds it on another address)
// BUSY    | access issued, waiting G_LAT cycles for memory read data
// DONE    | uprdy pulse, read data presented on updo
// WAITREL | wait for strobes or upen to drop before accepting another access
module up_ramcfg_nr1w_lat #(
  parameter int G_ADDR   = 10,
  parameter int G_WIDTH  = 32,
  parameter int G_NENG   = 2,
  parameter int G_LAT    = 3,
  parameter int G_STARVE = 15,
  parameter int G_BYPASS = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [G_NENG-1:0]           eng_re,
  input  logic [G_NENG*G_ADDR-1:0]    eng_ra,
  output logic [G_NENG*G_WIDTH-1:0]   eng_rdd,
  output logic [G_NENG-1:0]           eng_rvld,
  input  logic                        upen,
  input  logic [G_ADDR-1:0]           upa,
  input  logic                        upws,
  input  logic                        uprs,
  input  logic [G_WIDTH-1:0]          updi,
  output logic [G_WIDTH-1:0]          updo,
  output logic                        uprdy,
  output logic [G_NENG-1:0]           omemwe,
  output logic [G_NENG*G_ADDR-1:0]    omemad,
  output logic [G_NENG*G_WIDTH-1:0]   omemdi,
  input  logic [G_NENG*G_WIDTH-1:0]   imemdo
);

  localparam int SW = $clog2(G_STARVE + 1);
  localparam int LW = $clog2(G_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PEND    = 3'd1,
    S_BUSY    = 3'd2,
    S_DONE    = 3'd3,
    S_WAITREL = 3'd4
  } state_t;

  state_t                                state_q, state_d;
  logic [SW-1:0]                         starve_q, starve_d;
  logic [LW-1:0]                         lat_q, lat_d;
  logic                                  wr_q, wr_d;
  logic [G_WIDTH-1:0]                    updo_q, updo_d;
  logic [G_LAT-1:0][G_NENG-1:0]          vld_q, vld_d;
  logic [G_LAT-1:0][G_NENG-1:0]          byp_q, byp_d;
  logic [G_LAT-1:0][G_NENG-1:0][G_WIDTH-1:0] bdat_q, bdat_d;
  logic [G_NENG-1:0][G_WIDTH-1:0]        rdd_q, rdd_d;

  logic              req;
  logic              port_ok;
  logic              want;
  logic              grant;
  logic              wr_now;
  logic              cpu_we;
  logic [G_ADDR-1:0] eng_ra0;
  logic [G_NENG-1:0] acc;
  logic [G_NENG-1:0] byp_now;

  assign req     = upen & (upws | uprs);
  assign eng_ra0 = eng_ra[G_ADDR-1:0];
  assign port_ok = ~eng_re[0] | (eng_ra0 == upa) | (starve_q == SW'(G_STARVE));
  assign want    = ((state_q == S_IDLE) & req) | ((state_q == S_PEND) & upen);
  assign grant   = ~rst & want & port_ok;
  assign wr_now  = (state_q == S_IDLE) ? upws : wr_q;
  assign cpu_we  = grant & wr_now;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    lat_d    = lat_q;
    wr_d     = wr_q;
    updo_d   = updo_q;
    case (state_q)
      S_IDLE: begin
        starve_d = '0;
        if (req) begin
          wr_d = upws;
          if (grant) begin
            state_d = S_BUSY;
            lat_d   = LW'(G_LAT - 1);
          end else begin
            state_d  = S_PEND;
            starve_d = SW'(1);
          end
        end
      end
      S_PEND: begin
        if (!upen) begin
          state_d  = S_IDLE;
          starve_d = '0;
        end else if (grant) begin
          state_d  = S_BUSY;
          lat_d    = LW'(G_LAT - 1);
          starve_d = '0;
        end else if (starve_q != SW'(G_STARVE)) begin
          starve_d = starve_q + SW'(1);
        end
      end
      S_BUSY: begin
        if (!upen) begin
          state_d = S_IDLE;
        end else if (lat_q == '0) begin
          state_d = S_DONE;
          if (!wr_q) updo_d = imemdo[G_WIDTH-1:0];
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      S_DONE:    state_d = S_WAITREL;
      S_WAITREL: if (!upen || !(upws || uprs)) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // A forced grant to another address steals port 0 from engine 0 for this cycle.
  always_comb begin
    acc = eng_re;
    if (grant && (eng_ra0 != upa)) acc[0] = 1'b0;
    for (int i = 0; i < G_NENG; i++)
      byp_now[i] = (G_BYPASS != 0) && cpu_we && acc[i] && (eng_ra[i*G_ADDR +: G_ADDR] == upa);

    vld_d  = vld_q;
    byp_d  = byp_q;
    bdat_d = bdat_q;
    vld_d[0] = acc;
    byp_d[0] = byp_now;
    for (int i = 0; i < G_NENG; i++)
      bdat_d[0][i] = byp_now[i] ? updi : '0;
    for (int s = 1; s < G_LAT; s++) begin
      vld_d[s]  = vld_q[s-1];
      byp_d[s]  = byp_q[s-1];
      bdat_d[s] = bdat_q[s-1];
    end

    rdd_d   = rdd_q;
    eng_rdd = '0;
    for (int i = 0; i < G_NENG; i++) begin
      if (vld_q[G_LAT-1][i])
        rdd_d[i] = byp_q[G_LAT-1][i] ? bdat_q[G_LAT-1][i] : imemdo[i*G_WIDTH +: G_WIDTH];
      eng_rdd[i*G_WIDTH +: G_WIDTH] = rdd_d[i];
    end
  end

  always_comb begin
    omemwe    = '0;
    omemwe[0] = cpu_we;
    omemad    = eng_ra;
    omemad[G_ADDR-1:0] = grant ? upa : eng_ra0;
    omemdi    = '0;
    omemdi[G_WIDTH-1:0] = updi;
  end

  assign eng_rvld = vld_q[G_LAT-1];
  assign uprdy    = (state_q == S_DONE);
  assign updo     = updo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      starve_q <= '0;
      lat_q    <= '0;
      wr_q     <= 1'b0;
      updo_q   <= '0;
      vld_q    <= '0;
      byp_q    <= '0;
      bdat_q   <= '0;
      rdd_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      lat_q    <= lat_d;
      wr_q     <= wr_d;
      updo_q   <= updo_d;
      vld_q    <= vld_d;
      byp_q    <= byp_d;
      bdat_q   <= bdat_d;
      rdd_q    <= rdd_d;
    end
  end

endmodule
